// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI slave core.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int CPOL_IDLE_LOW  = 0;
  localparam int CPOL_IDLE_HIGH = 1;
  localparam int CPHA_LEADING   = 0;
  localparam int CPHA_TRAILING  = 1;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input, resetting to the line's idle level.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift chain; the reset value matches the idle level so release makes no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: synchronised sclk/cs_n/mosi, oversampled edge decode, word-level rx/tx handshakes.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              frame_start,
  output logic              frame_end,
  output logic [7:0]        word_cnt
);

  localparam int   BC_W      = $clog2(DATA_W);
  localparam logic SCLK_IDLE = (CPOL == CPOL_IDLE_HIGH);

  logic              sclk_s, cs_n_s, mosi_s;
  logic              sclk_d_r, cs_n_d_r;
  spi_state_e        state_r, state_nxt_s;
  logic [BC_W-1:0]   bit_cnt_r;
  logic [DATA_W-1:0] txsr_r;
  logic [DATA_W-2:0] rxsr_r;
  logic              miso_r, miso_oe_r, rx_valid_r, tx_load_r;
  logic              frame_start_r, frame_end_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [7:0]        word_cnt_r;

  logic              sclk_rise_s, sclk_fall_s, lead_s, trail_s;
  logic              sample_s, shift_s, cs_fall_s, cs_rise_s, word_done_s;
  logic [BC_W-1:0]   tx_idx_s;
  logic [DATA_W-1:0] rx_word_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  // Edge decode on the synchronised lines, mapped onto sample/shift by mode.
  always_comb begin
    sclk_rise_s = sclk_s & ~sclk_d_r;
    sclk_fall_s = ~sclk_s & sclk_d_r;
    if (CPOL == CPOL_IDLE_LOW) begin
      lead_s  = sclk_rise_s;
      trail_s = sclk_fall_s;
    end else begin
      lead_s  = sclk_fall_s;
      trail_s = sclk_rise_s;
    end
    if (CPHA == CPHA_LEADING) begin
      sample_s = lead_s;
      shift_s  = trail_s;
    end else begin
      sample_s = trail_s;
      shift_s  = lead_s;
    end
    cs_fall_s   = ~cs_n_s & cs_n_d_r;
    cs_rise_s   = cs_n_s & ~cs_n_d_r;
    tx_idx_s    = BC_W'(DATA_W - 1) - bit_cnt_r;
    rx_word_s   = {rxsr_r, mosi_s};
    word_done_s = (bit_cnt_r == BC_W'(DATA_W - 1));
  end

  // Frame state transitions.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) state_nxt_s = ACTIVE;
        else           state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (cs_rise_s) state_nxt_s = IDLE;
        else           state_nxt_s = ACTIVE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; cs_n deassertion outranks a coincident sclk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d_r      <= SCLK_IDLE;
      cs_n_d_r      <= 1'b1;
      state_r       <= IDLE;
      bit_cnt_r     <= {BC_W{1'b0}};
      txsr_r        <= {DATA_W{1'b0}};
      rxsr_r        <= {(DATA_W-1){1'b0}};
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
      rx_data_r     <= {DATA_W{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_load_r     <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      word_cnt_r    <= 8'd0;
    end else begin
      sclk_d_r      <= sclk_s;
      cs_n_d_r      <= cs_n_s;
      state_r       <= state_nxt_s;
      miso_oe_r     <= (state_nxt_s == ACTIVE);
      rx_valid_r    <= 1'b0;
      tx_load_r     <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            frame_start_r <= 1'b1;
            tx_load_r     <= 1'b1;
            txsr_r        <= tx_data;
            bit_cnt_r     <= {BC_W{1'b0}};
            rxsr_r        <= {(DATA_W-1){1'b0}};
            word_cnt_r    <= 8'd0;
            if (CPHA == CPHA_LEADING) miso_r <= tx_data[DATA_W-1];
          end
        end
        ACTIVE: begin
          if (cs_rise_s) begin
            frame_end_r <= 1'b1;
            bit_cnt_r   <= {BC_W{1'b0}};
            rxsr_r      <= {(DATA_W-1){1'b0}};
            miso_r      <= 1'b0;
          end else if (sample_s) begin
            rxsr_r <= rx_word_s[DATA_W-2:0];
            if (word_done_s) begin
              rx_data_r  <= rx_word_s;
              rx_valid_r <= 1'b1;
              bit_cnt_r  <= {BC_W{1'b0}};
              tx_load_r  <= 1'b1;
              txsr_r     <= tx_data;
              if (word_cnt_r != 8'hFF) word_cnt_r <= word_cnt_r + 8'd1;
            end else begin
              bit_cnt_r <= bit_cnt_r + BC_W'(1);
            end
          end else if (shift_s) begin
            miso_r <= txsr_r[tx_idx_s];
          end
        end
        default: bit_cnt_r <= {BC_W{1'b0}};
      endcase
    end
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_load     = tx_load_r;
  assign frame_start = frame_start_r;
  assign frame_end   = frame_end_r;
  assign word_cnt    = word_cnt_r;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: four 8-bit instances (modes 0..3) and one 16-bit mode-0 instance.
module tb_spi_slave_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mosi;
  logic        sclk_v [5];
  logic        cs_v   [5];
  logic [15:0] tx_v   [5];
  logic        miso_w [5], oe_w [5], rxv_w [5], txl_w [5], fs_w [5], fe_w [5];
  logic [7:0]  wc_w   [5];
  logic [7:0]  rx8    [4];
  logic [15:0] rx16;
  logic [15:0] rx_all [5];

  for (genvar g = 0; g < 4; g++) begin : g_m
    spi_slave_core #(.DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[g]), .cs_n(cs_v[g]), .mosi(mosi),
      .miso(miso_w[g]), .miso_oe(oe_w[g]), .rx_data(rx8[g]), .rx_valid(rxv_w[g]),
      .tx_data(tx_v[g][7:0]), .tx_load(txl_w[g]), .frame_start(fs_w[g]),
      .frame_end(fe_w[g]), .word_cnt(wc_w[g])
    );
    assign rx_all[g] = {8'h00, rx8[g]};
  end

  spi_slave_core #(.DATA_W(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(3)) u_w16 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[4]), .cs_n(cs_v[4]), .mosi(mosi),
    .miso(miso_w[4]), .miso_oe(oe_w[4]), .rx_data(rx16), .rx_valid(rxv_w[4]),
    .tx_data(tx_v[4]), .tx_load(txl_w[4]), .frame_start(fs_w[4]),
    .frame_end(fe_w[4]), .word_cnt(wc_w[4])
  );
  assign rx_all[4] = rx16;

  int checks = 0;
  int failures = 0;
  int rxv_cnt [5] = '{0, 0, 0, 0, 0};
  int txl_cnt [5] = '{0, 0, 0, 0, 0};
  int fs_cnt  [5] = '{0, 0, 0, 0, 0};
  int fe_cnt  [5] = '{0, 0, 0, 0, 0};
  logic [15:0] rx_hist [5][8];
  int b_rxv, b_txl, b_fs, b_fe;
  int lat_v [5];
  logic [15:0] mw [4];
  logic [15:0] tw [4];
  logic [15:0] cw [4];

  // Pulse counters and rx word history, sampled on the falling clk edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv_w[i] === 1'b1) begin
        rx_hist[i][rxv_cnt[i] % 8] <= rx_all[i];
        rxv_cnt[i] <= rxv_cnt[i] + 1;
      end
      if (txl_w[i] === 1'b1) txl_cnt[i] <= txl_cnt[i] + 1;
      if (fs_w[i] === 1'b1)  fs_cnt[i]  <= fs_cnt[i] + 1;
      if (fe_w[i] === 1'b1)  fe_cnt[i]  <= fe_cnt[i] + 1;
    end
  end

  function automatic int cpol_of(input int inst);
    return (inst == 2 || inst == 3) ? 1 : 0;
  endfunction

  function automatic int cpha_of(input int inst);
    return (inst == 1 || inst == 3) ? 1 : 0;
  endfunction

  task automatic snap(input int inst);
    @(negedge clk);
    b_rxv = rxv_cnt[inst]; b_txl = txl_cnt[inst]; b_fs = fs_cnt[inst]; b_fe = fe_cnt[inst];
  endtask

  // Half sclk period (8 clk); optionally measures clk cycles until rx_valid.
  task automatic half(input int inst, input bit meas);
    int lat;
    if (!meas) begin
      repeat (8) @(negedge clk);
    end else begin
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        if (rxv_w[inst] === 1'b1 && lat == 0) lat = k;
      end
      lat_v[inst] = lat;
      repeat (3) @(negedge clk);
    end
  endtask

  // Master frame: nbits clocked from mw[], miso captured into cw[], tx_v advanced per word.
  task automatic spi_frame(input int inst, input int wbits, input int nbits);
    int cpol, cpha, w, bi;
    cpol = cpol_of(inst);
    cpha = cpha_of(inst);
    for (int i = 0; i < 4; i++) cw[i] = 16'h0000;
    tx_v[inst] = tw[0];
    mosi = mw[0][wbits-1];
    cs_v[inst] = 1'b0;
    half(inst, 1'b0);
    for (int b = 0; b < nbits; b++) begin
      w  = b / wbits;
      bi = wbits - 1 - (b % wbits);
      sclk_v[inst] = (cpol == 0);
      if (cpha == 0) cw[w][bi] = miso_w[inst];
      else           mosi = mw[w][bi];
      if (bi == wbits - 1 && w < 3) tx_v[inst] = tw[w+1];
      half(inst, cpha == 0 && b == wbits - 1);
      sclk_v[inst] = (cpol != 0);
      if (cpha != 0) cw[w][bi] = miso_w[inst];
      else if (b + 1 < nbits) mosi = mw[(b+1) / wbits][wbits - 1 - ((b+1) % wbits)];
      half(inst, cpha != 0 && b == wbits - 1);
    end
    cs_v[inst] = 1'b1;
    mosi = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    int fs_sum;
    rst_n = 1'b0;
    mosi  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk_v[i] = (cpol_of(i) != 0);
      cs_v[i]   = 1'b1;
      tx_v[i]   = 16'hFFFF;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({miso_w[i], oe_w[i], rxv_w[i], txl_w[i], fs_w[i], fe_w[i], wc_w[i], rx_all[i]} !== 30'h0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got=%h required=0", i,
                 {miso_w[i], oe_w[i], rxv_w[i], txl_w[i], fs_w[i], fe_w[i], wc_w[i], rx_all[i]});
      end
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    fs_sum = fs_cnt[0] + fs_cnt[1] + fs_cnt[2] + fs_cnt[3] + fs_cnt[4];
    checks++;
    if (fs_sum != 0) begin
      failures++;
      $display("FAIL reset_release_false_start got=%0d required=0", fs_sum);
    end
  endtask

  task automatic test_mode0();
    mw[0] = 16'h003C; tw[0] = 16'h00A5; tw[1] = 16'h0000; tw[2] = 16'h0000; tw[3] = 16'h0000;
    snap(0);
    spi_frame(0, 8, 8);
    checks++; if (cw[0][7:0] !== 8'hA5) begin failures++; $display("FAIL mode0_miso got=%h required=a5", cw[0][7:0]); end
    checks++; if (rx_all[0] !== 16'h003C) begin failures++; $display("FAIL mode0_rx got=%h required=003c", rx_all[0]); end
    checks++; if (rxv_cnt[0] - b_rxv != 1) begin failures++; $display("FAIL mode0_rxv got=%0d required=1", rxv_cnt[0] - b_rxv); end
    checks++; if (wc_w[0] !== 8'd1) begin failures++; $display("FAIL mode0_wc got=%0d required=1", wc_w[0]); end
    checks++; if (fe_cnt[0] - b_fe != 1) begin failures++; $display("FAIL mode0_fe got=%0d required=1", fe_cnt[0] - b_fe); end
    checks++; if (txl_cnt[0] - b_txl != 2) begin failures++; $display("FAIL mode0_txl got=%0d required=2", txl_cnt[0] - b_txl); end
    checks++; if ({oe_w[0], miso_w[0]} !== 2'b00) begin failures++; $display("FAIL mode0_idle_miso got=%b required=00", {oe_w[0], miso_w[0]}); end
    checks++; if (lat_v[0] < 2 || lat_v[0] > 4) begin failures++; $display("FAIL mode0_latency got=%0d required=3", lat_v[0]); end
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      mw[0] = 16'h0096; tw[0] = 16'h0069; tw[1] = 16'h0000;
      snap(m);
      spi_frame(m, 8, 8);
      checks++; if (cw[0][7:0] !== 8'h69) begin failures++; $display("FAIL mode%0d_miso got=%h required=69", m, cw[0][7:0]); end
      checks++; if (rx_all[m] !== 16'h0096) begin failures++; $display("FAIL mode%0d_rx got=%h required=0096", m, rx_all[m]); end
      checks++; if (rxv_cnt[m] - b_rxv != 1) begin failures++; $display("FAIL mode%0d_rxv got=%0d required=1", m, rxv_cnt[m] - b_rxv); end
      checks++; if (wc_w[m] !== 8'd1) begin failures++; $display("FAIL mode%0d_wc got=%0d required=1", m, wc_w[m]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_rx [3];
    exp_rx[0] = 16'h1234; exp_rx[1] = 16'hABCD; exp_rx[2] = 16'h0F0F;
    mw[0] = 16'h1234; mw[1] = 16'hABCD; mw[2] = 16'h0F0F; mw[3] = 16'h0000;
    tw[0] = 16'hCAFE; tw[1] = 16'h0123; tw[2] = 16'hBEEF; tw[3] = 16'h5555;
    snap(4);
    spi_frame(4, 16, 48);
    checks++; if (rxv_cnt[4] - b_rxv != 3) begin failures++; $display("FAIL b2b_rxv got=%0d required=3", rxv_cnt[4] - b_rxv); end
    checks++; if (txl_cnt[4] - b_txl != 4) begin failures++; $display("FAIL b2b_txl got=%0d required=4", txl_cnt[4] - b_txl); end
    checks++; if (wc_w[4] !== 8'd3) begin failures++; $display("FAIL b2b_wc got=%0d required=3", wc_w[4]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx_hist[4][(b_rxv + k) % 8] !== exp_rx[k]) begin
        failures++; $display("FAIL b2b_rx%0d got=%h required=%h", k, rx_hist[4][(b_rxv + k) % 8], exp_rx[k]);
      end
      checks++;
      if (cw[k] !== tw[k]) begin failures++; $display("FAIL b2b_miso%0d got=%h required=%h", k, cw[k], tw[k]); end
    end
    checks++; if (lat_v[4] < 3 || lat_v[4] > 5) begin failures++; $display("FAIL b2b_latency got=%0d required=4", lat_v[4]); end
  endtask

  task automatic test_abort();
    mw[0] = 16'h00B3; tw[0] = 16'h0000; tw[1] = 16'h0000;
    snap(0);
    spi_frame(0, 8, 5);
    checks++; if (rxv_cnt[0] - b_rxv != 0) begin failures++; $display("FAIL abort_rxv got=%0d required=0", rxv_cnt[0] - b_rxv); end
    checks++; if (fe_cnt[0] - b_fe != 1) begin failures++; $display("FAIL abort_fe got=%0d required=1", fe_cnt[0] - b_fe); end
    checks++; if (wc_w[0] !== 8'd0) begin failures++; $display("FAIL abort_wc got=%0d required=0", wc_w[0]); end
    checks++; if (rx_all[0] !== 16'h003C) begin failures++; $display("FAIL abort_rx_held got=%h required=003c", rx_all[0]); end
    mw[0] = 16'h0081;
    snap(0);
    spi_frame(0, 8, 8);
    checks++; if (rx_all[0] !== 16'h0081) begin failures++; $display("FAIL abort_next_rx got=%h required=0081", rx_all[0]); end
    checks++; if (rxv_cnt[0] - b_rxv != 1) begin failures++; $display("FAIL abort_next_rxv got=%0d required=1", rxv_cnt[0] - b_rxv); end
  endtask

  task automatic test_cs_pulse();
    snap(0);
    cs_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    cs_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (fs_cnt[0] - b_fs != 1) begin failures++; $display("FAIL pulse_fs got=%0d required=1", fs_cnt[0] - b_fs); end
    checks++; if (txl_cnt[0] - b_txl != 1) begin failures++; $display("FAIL pulse_txl got=%0d required=1", txl_cnt[0] - b_txl); end
    checks++; if (fe_cnt[0] - b_fe != 1) begin failures++; $display("FAIL pulse_fe got=%0d required=1", fe_cnt[0] - b_fe); end
    checks++; if (rxv_cnt[0] - b_rxv != 0) begin failures++; $display("FAIL pulse_rxv got=%0d required=0", rxv_cnt[0] - b_rxv); end
    checks++; if (wc_w[0] !== 8'd0) begin failures++; $display("FAIL pulse_wc got=%0d required=0", wc_w[0]); end
  endtask

  task automatic test_same_edge();
    snap(0);
    cs_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    sclk_v[0] = 1'b1;
    cs_v[0]   = 1'b1;
    repeat (12) @(negedge clk);
    sclk_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (rxv_cnt[0] - b_rxv != 0) begin failures++; $display("FAIL same_edge_rxv got=%0d required=0", rxv_cnt[0] - b_rxv); end
    checks++; if (fe_cnt[0] - b_fe != 1) begin failures++; $display("FAIL same_edge_fe got=%0d required=1", fe_cnt[0] - b_fe); end
    mw[0] = 16'h005A; tw[0] = 16'h00C3;
    spi_frame(0, 8, 8);
    checks++; if (rx_all[0] !== 16'h005A) begin failures++; $display("FAIL same_edge_next_rx got=%h required=005a", rx_all[0]); end
    checks++; if (cw[0][7:0] !== 8'hC3) begin failures++; $display("FAIL same_edge_next_miso got=%h required=c3", cw[0][7:0]); end
  endtask

  task automatic test_reset_mid();
    cs_v[0] = 1'b0;
    mosi    = 1'b1;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      sclk_v[0] = 1'b1; repeat (8) @(negedge clk);
      sclk_v[0] = 1'b0; repeat (8) @(negedge clk);
    end
    snap(0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({miso_w[0], oe_w[0], rxv_w[0], txl_w[0], fs_w[0], fe_w[0], wc_w[0], rx_all[0]} !== 30'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h required=0",
               {miso_w[0], oe_w[0], rxv_w[0], txl_w[0], fs_w[0], fe_w[0], wc_w[0], rx_all[0]});
    end
    cs_v[0] = 1'b1;
    mosi    = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    checks++; if (fe_cnt[0] - b_fe != 0) begin failures++; $display("FAIL midreset_fe got=%0d required=0", fe_cnt[0] - b_fe); end
    checks++; if (fs_cnt[0] - b_fs != 0) begin failures++; $display("FAIL midreset_fs got=%0d required=0", fs_cnt[0] - b_fs); end
    mw[0] = 16'h00FF; tw[0] = 16'h0000;
    snap(0);
    spi_frame(0, 8, 8);
    checks++; if (rx_all[0] !== 16'h00FF) begin failures++; $display("FAIL midreset_rx got=%h required=00ff", rx_all[0]); end
    checks++; if (rxv_cnt[0] - b_rxv != 1) begin failures++; $display("FAIL midreset_rxv got=%0d required=1", rxv_cnt[0] - b_rxv); end
    checks++; if (wc_w[0] !== 8'd1) begin failures++; $display("FAIL midreset_wc got=%0d required=1", wc_w[0]); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_cs_pulse();
    test_same_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter DATA_W, default 8, shall set the word width; legal range 4..32.
REQ-002 Parameter CPOL, default 0, shall set the idle level of sclk.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter SYNC_STAGES, default 2, shall set the synchroniser depth on sclk, cs_n and mosi; legal range 2..3.
REQ-005 clk  input  1  peripheral clock; shall run at least 8x the sclk frequency.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-008 cs_n  input  1  chip select, active-low, asynchronous.
REQ-009 mosi  input  1  serial data in, MSB first.
REQ-010 miso  output  1  serial data out, MSB first, registered.
REQ-011 miso_oe  output  1  high while a frame is active; external tristate enable.
REQ-012 rx_data  output  DATA_W  last complete received word; held until the next word completes.
REQ-013 rx_valid  output  1  one-clk pulse; rx_data updated this cycle.
REQ-014 tx_data  input  DATA_W  next word to transmit; sampled in any cycle where tx_load=1.
REQ-015 tx_load  output  1  one-clk pulse; tx_data captured this cycle.
REQ-016 frame_start / frame_end  output  1 each  one-clk pulses on cs_n assert and deassert.
REQ-017 word_cnt  output  8  words completed in the current frame; saturates at 255.

Function
REQ-018 sclk, cs_n and mosi shall pass through SYNC_STAGES flops; all edge detection shall use the synchronised signals only.
REQ-019 Leading edge is rising when CPOL=0 and falling when CPOL=1.
- sample edge = leading if CPHA=0, else trailing.
- shift edge = the other edge.
REQ-020 The FSM shall have two states, IDLE and ACTIVE:
- IDLE->ACTIVE on a synchronised cs_n falling edge.
- ACTIVE->IDLE on a synchronised cs_n rising edge.
REQ-021 On entering ACTIVE, in the same cycle:
- frame_start=1 and tx_load=1.
- tx_data loads the tx shift register.
- bit_cnt=0 and word_cnt=0.
- If CPHA=0, miso shall take tx_data[DATA_W-1].
REQ-022 On each sample edge in ACTIVE, mosi shall shift into the rx shift register LSB-side and bit_cnt shall increment.
REQ-023 On the sample edge where bit_cnt==DATA_W-1, in the same cycle:
- rx_data gets the full word and rx_valid=1.
- bit_cnt wraps to 0.
- word_cnt increments, saturating at 255.
- tx_load=1 and the tx shift register reloads from tx_data.
REQ-024 On each shift edge in ACTIVE, miso shall take txsr[DATA_W-1-bit_cnt], so the MSB of a reloaded word is driven on the first shift edge after the reload.
REQ-025 rx_valid and tx_load shall each be asserted SYNC_STAGES+1 clk cycles (+/-1) after the sclk pin edge that completes the word.
REQ-026 On leaving ACTIVE, in the same cycle:
- frame_end=1.
- Any partial word shall be discarded, with no rx_valid.
- bit_cnt shall clear.
REQ-027 In IDLE, miso_oe=0 and miso=0.
REQ-028 If a sample or shift edge coincides with cs_n deassertion, the deassertion shall win and the edge shall be ignored.
REQ-029 Edges of sclk shall be ignored while in IDLE.
REQ-030 A cs_n pulse with no sclk edges shall produce frame_start, tx_load and frame_end, with no rx_valid and word_cnt=0.
REQ-031 word_cnt shall hold its value after frame_end until the next frame_start.

Reset
REQ-032 While rst_n=0:
- All outputs shall be 0.
- The FSM shall be in IDLE.
- bit_cnt, both shift registers and word_cnt shall be 0.
REQ-033 Synchroniser flops shall reset to idle levels (sclk=CPOL, cs_n=1, mosi=0) so that no false edge occurs on release.
REQ-034 Reset asserted mid-frame shall abort the frame with no frame_end pulse.

Structure
REQ-035 Package spi_pkg shall hold the FSM state enum (IDLE, ACTIVE) and the CPOL/CPHA mode constants.
REQ-036 The synchroniser shall be a separate sub-module, spi_sync, parametrised by SYNC_STAGES, with one instance per input.
REQ-037 All other logic shall be a single clocked process plus combinational edge decode.

Verification
REQ-038 Mode 0, DATA_W=8, tx_data=0xA5, master sends 0x3C -> miso stream 10100101, one rx_valid with rx_data=0x3C, word_cnt=1, frame_end once.
REQ-039 Modes 1, 2 and 3, each sending 0x96 with tx_data=0x69 -> correct rx_data=0x96 and miso stream 01101001 in every mode.
REQ-040 DATA_W=16, three back-to-back words 0x1234, 0xABCD, 0x0F0F in one frame -> three rx_valid pulses, tx_load pulses at frame start plus after words 1 and 2 (and word 3), word_cnt=3.
REQ-041 cs_n deasserted after 5 of 8 bits -> no rx_valid, frame_end=1, next frame receives 0x81 correctly.
REQ-042 rst_n pulsed low mid-word, then a frame sends 0xFF -> all outputs 0 during reset, no frame_end, then rx_data=0xFF.
REQ-043 cs_n deasserted in the same clk as a synchronised sample edge -> edge ignored, bit_cnt=0, no rx_valid.
